// File: rtl/skein_sched_pkg.sv
// Shared types for the skein512 nonce scheduler: FSM states, widths, tag-line entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package skein_sched_pkg;

  localparam int NONCE_W  = 32;
  localparam int TARGET_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // One tag-line stage: marks whether the core_hash aligned with it belongs to a real nonce
  typedef struct packed {
    logic               vld;
    logic [NONCE_W-1:0] nonce;
  } tag_t;

endpackage

// File: rtl/gn_fifo.sv
// Golden-nonce queue: DEPTH x WIDTH synchronous FIFO, head held in flops, full/empty flags.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push while full is dropped (drop_o) unless a pop frees the slot the same cycle.
module gn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i && !empty_o;
  // A same-cycle pop makes room, so a push into a full queue still lands
  assign do_push    = push_i && (!full_o || do_pop);
  assign drop_o     = push_i && !do_push;
  assign head_dat_o = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/skein_nonce_sched.sv
// Job sequencer for skein512: one nonce per 2 clocks, tracks results, queues golden nonces.
// Latency: core_nonce valid 1 clk after job_start; gn_valid 1 clk after qualifying core_hash.
// Backpressure: gn_valid/gn_ready; full queue drops results and sets sticky overflow.
// Optional: define SKEIN_SCHED_HASHCNT_EN to add the hash_count result counter output.
module skein_nonce_sched
  import skein_sched_pkg::*;
#(
  parameter int HASH_LATENCY = 184,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                job_start,
  input  logic                job_abort,
  input  logic [511:0]        job_midstate,
  input  logic [95:0]         job_data,
  input  logic [NONCE_W-1:0]  job_nonce_first,
  input  logic [NONCE_W-1:0]  job_nonce_last,
  input  logic [TARGET_W-1:0] job_target,
  output logic [511:0]        core_midstate,
  output logic [95:0]         core_data,
  output logic [NONCE_W-1:0]  core_nonce,
  input  logic [511:0]        core_hash,
  output logic                gn_valid,
  input  logic                gn_ready,
  output logic [NONCE_W-1:0]  gn_nonce,
  output logic                busy,
  output logic                done,
  output logic                overflow
`ifdef SKEIN_SCHED_HASHCNT_EN
  ,
  output logic [31:0]         hash_count
`endif
);

  localparam int CNT_W = $clog2(HASH_LATENCY + 1);

  state_e               state_q;
  logic                 stride_q;
  logic [CNT_W-1:0]     drain_cnt_q;
  logic [511:0]         core_midstate_q;
  logic [95:0]          core_data_q;
  logic [NONCE_W-1:0]   core_nonce_q, nonce_d, last_q;
  logic [TARGET_W-1:0]  target_q;
  logic                 done_q, overflow_q;

  tag_t                 tag_q [HASH_LATENCY];
  tag_t                 tag_d, tag_out;
  logic                 issue, abort, accept_start, qualify;
  logic                 fifo_empty, fifo_drop, fifo_full_unused;
  logic                 hash_tail_unused;

  // Stride bit 0 in RUN is the cycle the core picks up a new nonce
  assign issue        = (state_q == ST_RUN) && !stride_q;
  assign abort        = job_abort && (state_q != ST_IDLE);
  assign accept_start = job_start && (state_q == ST_IDLE);
  assign nonce_d      = core_nonce_q + 32'd1;
  assign tag_d        = '{vld: issue, nonce: core_nonce_q};
  assign tag_out      = tag_q[HASH_LATENCY-1];
  assign qualify      = tag_out.vld && (core_hash[511:448] <= target_q);
  assign hash_tail_unused = ^core_hash[447:0];

  // Job FSM: latches the job, steps the nonce on stride boundaries, times the drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      stride_q        <= 1'b0;
      drain_cnt_q     <= '0;
      core_midstate_q <= '0;
      core_data_q     <= '0;
      core_nonce_q    <= '0;
      last_q          <= '0;
      target_q        <= '0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_drop) overflow_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (job_start) begin
            core_midstate_q <= job_midstate;
            core_data_q     <= job_data;
            core_nonce_q    <= job_nonce_first;
            last_q          <= job_nonce_last;
            target_q        <= job_target;
            stride_q        <= 1'b0;
            overflow_q      <= 1'b0;
            state_q         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (job_abort) begin
            state_q <= ST_IDLE;
          end else begin
            stride_q <= ~stride_q;
            if (!stride_q) begin
              // Last nonce issued: hold it and wait for its result to come back
              if (core_nonce_q == last_q) begin
                state_q     <= ST_DRAIN;
                drain_cnt_q <= '0;
              end
            end else begin
              core_nonce_q <= nonce_d;
            end
          end
        end
        ST_DRAIN: begin
          if (job_abort) begin
            state_q <= ST_IDLE;
          end else if (drain_cnt_q == CNT_W'(HASH_LATENCY)) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tag line mirroring the core pipeline; its last stage lines up with core_hash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HASH_LATENCY; i++) tag_q[i] <= '0;
    end else if (abort) begin
      for (int i = 0; i < HASH_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < HASH_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  gn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_gn_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (qualify),
    .push_dat_i (tag_out.nonce),
    .pop_i      (gn_ready),
    .head_dat_o (gn_nonce),
    .full_o     (fifo_full_unused),
    .empty_o    (fifo_empty),
    .drop_o     (fifo_drop)
  );

`ifdef SKEIN_SCHED_HASHCNT_EN
  logic [31:0] hash_count_q;

  // Counts every result that belonged to an issued nonce, restarted per job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_count_q <= '0;
    end else if (accept_start) begin
      hash_count_q <= '0;
    end else if (tag_out.vld) begin
      hash_count_q <= hash_count_q + 32'd1;
    end
  end

  assign hash_count = hash_count_q;
`else
  logic start_unused;
  assign start_unused = accept_start;
`endif

  assign core_midstate = core_midstate_q;
  assign core_data     = core_data_q;
  assign core_nonce    = core_nonce_q;
  assign gn_valid      = !fifo_empty;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule
